timestamp_reader: RTL and testbench
===================================

Name: timestamp_reader

Overview:
- Bus initiator on the single-cycle-handshake memory bus (valid/ready/addr/rdata/wdata/wstrb) used by the free-running 64-bit cycle-counter peripheral.
- On request, it performs a hi-lo-hi read sequence of two 32-bit words and returns a tear-free 64-bit timestamp.
- Serves trace/profiling logic that needs consistent timestamps without occupying the CPU.

Parameters:
- BASE_ADDR, 32'h0000_0000: byte address of the counter peripheral; the low word is at BASE_ADDR+0 and the high word at BASE_ADDR+4.
- MAX_RETRY, 3: number of lo+hi re-reads allowed after a high-word mismatch before error (range 0-15).
- TIMEOUT, 255: maximum cycles m_valid may wait for m_ready before abort (range 1-65535).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- req  input  1  start a capture; sampled only in IDLE
- busy  output  1  high from the cycle after req is accepted until done/err
- done  output  1  one-cycle pulse; stamp valid
- err  output  1  one-cycle pulse; retry limit exceeded or timeout
- stamp  output  64  captured timestamp; held until the next done
- m_valid  output  1  bus request
- m_ready  input  1  bus acknowledge; a transfer completes in any cycle with m_valid & m_ready
- m_addr  output  32  byte address
- m_rdata  input  32  read data; sampled in the completing cycle
- m_wdata  output  32  constant 0
- m_wstrb  output  4  constant 4'b0000 (reads only)

Behaviour:
- Reset values: busy=0, done=0, err=0, stamp=0, m_valid=0, m_addr=0; state=IDLE; retry count=0; timeout count=0.
- States: IDLE, RD_HI1, GAP1, RD_LO, GAP2, RD_HI2, FIN.
  - IDLE: req=1 -> RD_HI1 with busy=1 next cycle. req while not IDLE is ignored (no queueing).
  - RD_HI1: m_valid=1, m_addr=BASE_ADDR+4. On completion, latch hi1 and go to GAP1.
  - GAP1: m_valid=0 for exactly one cycle, then RD_LO. Every transfer is followed by one idle cycle so the responder's registered acknowledge clears.
  - RD_LO: m_addr=BASE_ADDR+0. On completion, latch lo and go to GAP2.
  - GAP2: one idle cycle, then RD_HI2.
  - RD_HI2: m_addr=BASE_ADDR+4. On completion, latch hi2 and go to FIN.
  - FIN (one cycle, m_valid=0):
    - hi2==hi1: stamp={hi1,lo}, done=1 for one cycle, busy=0, go to IDLE.
    - hi2!=hi1 and retry<MAX_RETRY: hi1<=hi2, retry+1, go to RD_LO.
    - hi2!=hi1 and retry==MAX_RETRY: err=1, busy=0, stamp unchanged, go to IDLE.
- m_addr and m_valid are held stable while waiting for m_ready. m_addr is registered and changes only on state entry. m_ready is ignored when m_valid=0.
- Timeout: counts cycles with m_valid=1 & m_ready=0 in the current transfer, cleared on each completion. Reaching TIMEOUT forces m_valid=0, err=1, and a return to IDLE the next cycle.
- Retry counter is 4 bits and clears on leaving IDLE.
- Minimum latency with zero-wait-state ready: done asserts 7 cycles after the req cycle. Against the registered-acknowledge responder (ready one cycle after valid), latency is 10 cycles.
- done and err are mutually exclusive and never asserted together with busy in the same cycle.
- reset asserted mid-sequence: next cycle all outputs are at reset values, and any in-flight transfer is abandoned.

Test Plan:
- Zero-wait responder: lo=32'h0000_0010, hi=32'h0000_0002 constant; pulse req -> m_addr sequence BASE+4, BASE+0, BASE+4; done on cycle 7; stamp=64'h0000_0002_0000_0010; busy=0 same cycle.
- Registered-ack counter model starting at 64'h0000_0000_FFFF_FFF8: req -> first hi=0, lo read after the wrap, hi2=1 -> one retry -> stamp=64'h0000_0001_xxxx (low word less than 32'h20), hi equals final hi read, done once.
- Responder returning a different hi every read with MAX_RETRY=2 -> exactly 3 lo reads and 4 hi reads, then err pulse, stamp keeps its prior value, done never asserted.
- m_ready stuck 0 with TIMEOUT=5 -> m_valid high exactly 5 cycles then low, err pulse the following cycle, state IDLE; a new req then completes normally.
- req held high continuously -> captures back-to-back, one idle cycle in IDLE between sequences, no extra transfers; req during busy is ignored.
- reset asserted during RD_LO with m_valid=1 -> next cycle m_valid=0, busy=0, stamp=0; no done or err pulse.
- Throughout all scenarios: m_wstrb is always 0, m_wdata is always 0, and m_addr is stable while m_valid=1 and m_ready=0.

Source files
------------

// File: rtl/timestamp_reader_if.sv
// Single-cycle-handshake memory bus used by the 64-bit cycle-counter peripheral.
// A transfer completes in any cycle where m_valid and m_ready are both high.
// Signals:
//   m_valid  initiator request
//   m_ready  responder acknowledge
//   m_addr   byte address
//   m_rdata  read data, valid in the completing cycle
//   m_wdata  write data
//   m_wstrb  byte write strobes (all zero for a read)
// Modports: master (initiator side), slave (responder side).
interface timestamp_reader_if;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_addr;
  logic [31:0] m_rdata;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;

  modport master (
    output m_valid, m_addr, m_wdata, m_wstrb,
    input  m_ready, m_rdata
  );

  modport slave (
    input  m_valid, m_addr, m_wdata, m_wstrb,
    output m_ready, m_rdata
  );
endinterface

// File: rtl/timestamp_reader.sv
// Tear-free 64-bit timestamp reader.
// On req it reads the counter peripheral in hi-lo-hi order. If both high
// reads agree, {hi,lo} is published as stamp; otherwise the low/high pair is
// re-read up to MAX_RETRY times before an err pulse. Every bus transfer is
// followed by one idle cycle so a registered-acknowledge responder can clear.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   req         start a capture (only sampled while idle)
//   busy        capture in progress
//   done        one-cycle pulse, stamp updated
//   err         one-cycle pulse, retry limit exceeded or bus timeout
//   stamp       last good timestamp
//   bus         master side of the counter bus (read-only use)
module timestamp_reader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [63:0]        stamp,
  timestamp_reader_if.master bus
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] RD_HI1 = 3'd1;
  localparam logic [2:0] GAP1   = 3'd2;
  localparam logic [2:0] RD_LO  = 3'd3;
  localparam logic [2:0] GAP2   = 3'd4;
  localparam logic [2:0] RD_HI2 = 3'd5;
  localparam logic [2:0] FIN    = 3'd6;

  localparam logic [3:0]  RETRY_LIM = 4'(MAX_RETRY);
  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);
  localparam logic [31:0] ADDR_LO   = BASE_ADDR;
  localparam logic [31:0] ADDR_HI   = BASE_ADDR + 32'd4;

  logic [2:0]  state;
  logic [3:0]  retry;
  logic [15:0] tmo_cnt;
  logic [31:0] hi1;
  logic [31:0] hi2;
  logic [31:0] lo;
  logic        xfer_done;
  logic        tmo_hit;

  assign xfer_done = bus.m_valid & bus.m_ready;
  // Wait cycles are counted before this one, so the last allowed cycle is TIMEOUT-1.
  assign tmo_hit   = bus.m_valid & ~bus.m_ready & (tmo_cnt == TMO_LAST);

  assign bus.m_wdata = '0;
  assign bus.m_wstrb = '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      stamp       <= '0;
      retry       <= '0;
      tmo_cnt     <= '0;
      hi1         <= '0;
      hi2         <= '0;
      lo          <= '0;
      bus.m_valid <= 1'b0;
      bus.m_addr  <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (tmo_hit) begin
        bus.m_valid <= 1'b0;
        err         <= 1'b1;
        busy        <= 1'b0;
        tmo_cnt     <= '0;
        state       <= IDLE;
      end else begin
        if (xfer_done) begin
          tmo_cnt <= '0;
        end else if (bus.m_valid) begin
          tmo_cnt <= tmo_cnt + 16'd1;
        end

        case (state)
          IDLE: begin
            if (req) begin
              busy        <= 1'b1;
              retry       <= '0;
              bus.m_valid <= 1'b1;
              bus.m_addr  <= ADDR_HI;
              state       <= RD_HI1;
            end
          end
          RD_HI1: begin
            if (xfer_done) begin
              hi1         <= bus.m_rdata;
              bus.m_valid <= 1'b0;
              state       <= GAP1;
            end
          end
          GAP1: begin
            bus.m_valid <= 1'b1;
            bus.m_addr  <= ADDR_LO;
            state       <= RD_LO;
          end
          RD_LO: begin
            if (xfer_done) begin
              lo          <= bus.m_rdata;
              bus.m_valid <= 1'b0;
              state       <= GAP2;
            end
          end
          GAP2: begin
            bus.m_valid <= 1'b1;
            bus.m_addr  <= ADDR_HI;
            state       <= RD_HI2;
          end
          RD_HI2: begin
            if (xfer_done) begin
              hi2         <= bus.m_rdata;
              bus.m_valid <= 1'b0;
              state       <= FIN;
            end
          end
          FIN: begin
            if (hi2 == hi1) begin
              stamp <= {hi1, lo};
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else if (retry < RETRY_LIM) begin
              // The newer high word becomes the reference for the re-read pair.
              hi1         <= hi2;
              retry       <= retry + 4'd1;
              bus.m_valid <= 1'b1;
              bus.m_addr  <= ADDR_LO;
              state       <= RD_LO;
            end else begin
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
          default: begin
            bus.m_valid <= 1'b0;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_timestamp_reader.sv
// Directed bench for timestamp_reader: zero-wait and registered-ack responders,
// a live 64-bit counter with a low-word wrap, persistent high-word mismatch,
// bus timeout, back-to-back requests and mid-sequence reset.
`timescale 1ns/1ps
module tb_timestamp_reader;

  localparam logic [31:0] BASE = 32'h4000_0100;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        busy;
  logic        done;
  logic        err;
  logic [63:0] stamp;

  timestamp_reader_if bus ();

  timestamp_reader #(
    .BASE_ADDR (BASE),
    .MAX_RETRY (2),
    .TIMEOUT   (5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .stamp (stamp),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ---------------- responder ----------------
  // mode 0: zero-wait, constant hi=2 lo=0x10
  // mode 1: registered ack, live counter cnt_base+cyc
  // mode 2: registered ack, new high word on every high read
  // mode 3: ready stuck low
  int          mode = 0;
  logic        ready_q = 1'b0;
  logic [63:0] cyc = '0;
  logic [63:0] cnt_base = '0;
  logic [63:0] cnt_val;
  logic [31:0] hi_var = 32'h0000_0100;
  logic        is_hi;

  always @(posedge clk) cyc <= cyc + 64'd1;
  always @(posedge clk) ready_q <= bus.m_valid & ~ready_q;
  always @(posedge clk)
    if (bus.m_valid && bus.m_ready && is_hi) hi_var <= hi_var + 32'h11;

  assign cnt_val = cnt_base + cyc;
  assign is_hi   = (bus.m_addr == BASE + 32'd4);

  assign bus.m_ready = (mode == 0) ? 1'b1 : (mode == 3) ? 1'b0 : ready_q;
  assign bus.m_rdata = (mode == 0) ? (is_hi ? 32'h0000_0002 : 32'h0000_0010) :
                       (mode == 1) ? (is_hi ? cnt_val[63:32] : cnt_val[31:0]) :
                                     (is_hi ? hi_var : 32'h0000_0055);

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- bus monitor ----------------
  int          n_lo = 0, n_hi = 0, n_done = 0, n_err = 0, n_vcyc = 0;
  logic [31:0] addr_log[$];
  logic        prev_wait = 1'b0;
  logic [31:0] prev_addr = '0;

  always @(negedge clk) begin
    check_eq("wstrb_zero", 64'(bus.m_wstrb), 64'd0);
    check_eq("wdata_zero", 64'(bus.m_wdata), 64'd0);
    check_eq("done_and_busy", 64'(done & busy), 64'd0);
    check_eq("done_and_err", 64'(done & err), 64'd0);
    if (prev_wait && bus.m_valid)
      check_eq("addr_stable", 64'(bus.m_addr), 64'(prev_addr));
    prev_wait = bus.m_valid & ~bus.m_ready;
    prev_addr = bus.m_addr;
    if (bus.m_valid) n_vcyc++;
    if (done) n_done++;
    if (err) n_err++;
    if (bus.m_valid && bus.m_ready) begin
      addr_log.push_back(bus.m_addr);
      if (is_hi) n_hi++;
      else n_lo++;
    end
  end

  // ---------------- stimulus ----------------
  int b_lo, b_hi, b_done, b_err, b_v, b_log;

  task automatic snap();
    b_lo = n_lo; b_hi = n_hi; b_done = n_done; b_err = n_err;
    b_v = n_vcyc; b_log = addr_log.size();
  endtask

  // Call at a negedge. Returns with done or err visible; lat counts edges from
  // the one that sampled req.
  task automatic run_req(input int budget, output int lat);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    lat = 1;
    while (!(done || err) && lat < budget) begin
      @(negedge clk);
      lat++;
    end
    check_eq("wait_bound", 64'(done | err), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    reset = 1'b1;
    req   = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_err", 64'(err), 64'd0);
    check_eq("rst_stamp", stamp, 64'd0);
    check_eq("rst_valid", 64'(bus.m_valid), 64'd0);
    check_eq("rst_addr", 64'(bus.m_addr), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // zero-wait capture
    mode = 0;
    snap();
    run_req(30, lat);
    check_eq("zw_latency", 64'(lat), 64'd7);
    check_eq("zw_done", 64'(done), 64'd1);
    check_eq("zw_busy_at_done", 64'(busy), 64'd0);
    check_eq("zw_stamp", stamp, 64'h0000_0002_0000_0010);
    @(negedge clk);
    check_eq("zw_addr0", 64'(addr_log[b_log]), 64'(BASE + 32'd4));
    check_eq("zw_addr1", 64'(addr_log[b_log + 1]), 64'(BASE));
    check_eq("zw_addr2", 64'(addr_log[b_log + 2]), 64'(BASE + 32'd4));
    check_eq("zw_xfers", 64'(addr_log.size() - b_log), 64'd3);
    check_eq("zw_done_cnt", 64'(n_done - b_done), 64'd1);

    // live counter across a low-word wrap: one retry
    mode = 1;
    repeat (2) @(negedge clk);
    snap();
    cnt_base = 64'h0000_0000_FFFF_FFF8 - cyc;
    run_req(40, lat);
    check_eq("ctr_latency", 64'(lat), 64'd16);
    check_eq("ctr_done", 64'(done), 64'd1);
    check_eq("ctr_stamp", stamp, 64'h0000_0001_0000_0003);
    @(negedge clk);
    check_eq("ctr_done_cnt", 64'(n_done - b_done), 64'd1);
    check_eq("ctr_lo_reads", 64'(n_lo - b_lo), 64'd2);
    check_eq("ctr_hi_reads", 64'(n_hi - b_hi), 64'd3);
    check_eq("ctr_err_cnt", 64'(n_err - b_err), 64'd0);

    // high word never stable: retries exhausted
    mode = 2;
    repeat (2) @(negedge clk);
    snap();
    run_req(60, lat);
    check_eq("rty_latency", 64'(lat), 64'd22);
    check_eq("rty_err", 64'(err), 64'd1);
    check_eq("rty_busy", 64'(busy), 64'd0);
    check_eq("rty_stamp_kept", stamp, 64'h0000_0001_0000_0003);
    @(negedge clk);
    check_eq("rty_lo_reads", 64'(n_lo - b_lo), 64'd3);
    check_eq("rty_hi_reads", 64'(n_hi - b_hi), 64'd4);
    check_eq("rty_done_cnt", 64'(n_done - b_done), 64'd0);
    check_eq("rty_err_cnt", 64'(n_err - b_err), 64'd1);

    // ready stuck low: timeout
    mode = 3;
    repeat (2) @(negedge clk);
    snap();
    run_req(30, lat);
    check_eq("tmo_latency", 64'(lat), 64'd6);
    check_eq("tmo_err", 64'(err), 64'd1);
    check_eq("tmo_valid_low", 64'(bus.m_valid), 64'd0);
    check_eq("tmo_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check_eq("tmo_valid_cycles", 64'(n_vcyc - b_v), 64'd5);
    check_eq("tmo_done_cnt", 64'(n_done - b_done), 64'd0);
    check_eq("tmo_err_cnt", 64'(n_err - b_err), 64'd1);
    mode = 0;
    run_req(30, lat);
    check_eq("tmo_recover_lat", 64'(lat), 64'd7);
    check_eq("tmo_recover_stamp", stamp, 64'h0000_0002_0000_0010);
    @(negedge clk);

    // req held high: back-to-back captures, period 7
    snap();
    req = 1'b1;
    repeat (21) @(negedge clk);
    req = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("b2b_done_cnt", 64'(n_done - b_done), 64'd3);
    check_eq("b2b_lo_reads", 64'(n_lo - b_lo), 64'd3);
    check_eq("b2b_hi_reads", 64'(n_hi - b_hi), 64'd6);
    check_eq("b2b_err_cnt", 64'(n_err - b_err), 64'd0);

    // reset while RD_LO is waiting for ready
    mode = 1;
    repeat (2) @(negedge clk);
    snap();
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("mid_lo_valid", 64'(bus.m_valid), 64'd1);
    check_eq("mid_lo_addr", 64'(bus.m_addr), 64'(BASE));
    reset = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_valid", 64'(bus.m_valid), 64'd0);
    check_eq("mid_rst_busy", 64'(busy), 64'd0);
    check_eq("mid_rst_stamp", stamp, 64'd0);
    check_eq("mid_rst_addr", 64'(bus.m_addr), 64'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("mid_rst_done_cnt", 64'(n_done - b_done), 64'd0);
    check_eq("mid_rst_err_cnt", 64'(n_err - b_err), 64'd0);
    check_eq("mid_rst_lo_reads", 64'(n_lo - b_lo), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
